// File: rtl/uart_tx_port.sv
// ---------------------------------------------------------------------------
// uart_tx_port
//
// Memory-mapped 8N1 UART transmitter for the CPU6 system bus. CPU writes to
// BASE_ADDR are queued in a small FIFO and shifted out LSB first on tx.
//
// Register map:
//   BASE_ADDR     W: push data_in into the FIFO        R: 8'h00
//   BASE_ADDR+1   W: data_in[2]=1 clears overflow      R: status
//                 status = {5'b0, overflow, tx_idle, tx_ready}
//
// Ports:
//   clock     in   system clock, all state updates on posedge
//   reset     in   asynchronous active-low reset
//   address   in   [15:0] CPU bus address
//   write_en  in   CPU write strobe, sampled on posedge clock
//   data_in   in   [7:0] CPU write data
//   data_out  out  [7:0] read data, combinational from address
//   tx        out  registered serial output, idles high
//   irq       out  high while the FIFO is empty and the shifter is idle
// ---------------------------------------------------------------------------
module uart_tx_port #(
  parameter logic [15:0] BASE_ADDR    = 16'hF200,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        write_en,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        tx,
  output logic        irq
);

  localparam int              PTR_W       = $clog2(FIFO_DEPTH);
  localparam int              CNT_W       = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]     BAUD_LAST   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]     STATUS_ADDR = BASE_ADDR + 16'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Transmit shifter
  state_e      state_q, state_d;
  logic [15:0] baud_q,  baud_d;
  logic [2:0]  bit_q,   bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q,    tx_d;
  logic        overflow_q, overflow_d;

  logic fifo_empty;
  logic fifo_full;
  logic tx_idle;
  logic baud_wrap;
  logic push_req;
  logic push;
  logic pop;
  logic clear_req;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign tx_idle    = fifo_empty && (state_q == ST_IDLE);
  assign baud_wrap  = (baud_q == BAUD_LAST);
  assign push_req   = write_en && (address == BASE_ADDR);
  assign clear_req  = write_en && (address == STATUS_ADDR) && data_in[2];

  // A full FIFO still accepts a byte when the shifter drains one on the
  // same edge, so the count simply stays at FIFO_DEPTH.
  assign push = push_req && (!fifo_full || pop);

  // -------------------------------------------------------------------------
  // Shifter FSM: next state, pop request and next serial level
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    baud_d  = baud_wrap ? 16'd0 : baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        baud_d = 16'd0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end

      ST_START: begin
        if (baud_wrap) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end

      ST_DATA: begin
        if (baud_wrap) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[bit_q + 3'd1];
          end
        end
      end

      ST_STOP: begin
        // Next byte starts straight out of the stop bit with no idle gap.
        if (baud_wrap) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO pointers, count and sticky overflow
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Clear and set come from different addresses, so they never collide.
    if (clear_req) begin
      overflow_d = 1'b0;
    end
    if (push_req && !push) begin
      overflow_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= 16'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q gates every
  // read, so stale contents are never observed and the array can map to RAM.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    data_out = 8'h00;
    if (address == STATUS_ADDR) begin
      data_out = {5'b00000, overflow_q, tx_idle, !fifo_full};
    end
  end

  assign tx  = tx_q;
  assign irq = tx_idle;

endmodule
